// File: rtl/mouse_step_sched.sv
// -----------------------------------------------------------------------------
// mouse_step_sched
//
// Buffers PS/2 mouse packets from the HPS packet bus in a small FIFO. Each
// packet is then replayed as a paced train of single X/Y step pulses for the
// quadrature/joystick emulation. The button level is updated only when the
// packet it belongs to starts replaying, so buttons stay aligned with motion.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ce         clock enable for the step-rate divider
//   ps2_mouse  [24] toggle strobe, [23:16] Y, [15:8] X, [7] YOVR, [6] XOVR,
//              [5] YSGN, [4] XSGN, [2:0] buttons
//   rate       step period in ce cycles, minus one
//   clr_ovf    synchronous clear of ovf
//   x_step     one-clk pulse per X step; x_dir is valid with it (1 = negative)
//   y_step     one-clk pulse per Y step; y_dir is valid with it (1 = negative)
//   button     active-low: 0 while any button of the current packet is pressed
//   busy       replay in progress or packets still queued
//   ovf        sticky: a packet was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module mouse_step_sched #(
   parameter int FIFO_AW = 2,
   parameter int DIV_W   = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [24:0]      ps2_mouse,
   input  logic [DIV_W-1:0] rate,
   input  logic             clr_ovf,
   output logic             x_step,
   output logic             x_dir,
   output logic             y_step,
   output logic             y_dir,
   output logic             button,
   output logic             busy,
   output logic             ovf
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = 23;
   localparam logic [FIFO_AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   // Entry layout: {btn[2:0], XOVR, XSGN, X[7:0], YOVR, YSGN, Y[7:0]}
   function automatic logic [8:0] axis_mag(input logic ovr, input logic sgn,
                                           input logic [7:0] mv);
      logic [8:0] v;
      v = {sgn, mv};
      if (ovr)
         return 9'd255;
      // -256 negates to 9'h100, which is exactly the 256 steps wanted
      return sgn ? (~v + 9'd1) : v;
   endfunction

   state_t           r_state, w_next_state;
   logic             r_old_stb;
   logic [EW-1:0]    r_mem [DEPTH];
   logic [FIFO_AW:0] r_wptr, r_rptr;
   logic [EW-1:0]    r_pkt;
   logic [DIV_W-1:0] r_div;
   logic [8:0]       r_xcnt, r_ycnt;
   logic             r_xsgn, r_ysgn;
   logic             r_x_step, r_x_dir, r_y_step, r_y_dir, r_button, r_ovf;

   logic             w_strobe, w_empty, w_full, w_pop, w_push, w_drop;
   logic [EW-1:0]    w_entry;
   logic             w_tick, w_run_tick, w_xhit, w_yhit;
   logic [8:0]       w_xmag, w_ymag;
   logic             w_unused;

   assign w_unused = ps2_mouse[3];
   assign w_strobe = ps2_mouse[24] ^ r_old_stb;
   assign w_entry  = {ps2_mouse[2:0], ps2_mouse[6], ps2_mouse[4], ps2_mouse[15:8],
                      ps2_mouse[7], ps2_mouse[5], ps2_mouse[23:16]};

   // Extra pointer bit separates full from empty when the indices match
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                    (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
   assign w_pop   = (r_state == S_IDLE) && !w_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts
   assign w_push  = w_strobe && (!w_full || w_pop);
   assign w_drop  = w_strobe && w_full && !w_pop;

   assign w_xmag = axis_mag(r_pkt[19], r_pkt[18], r_pkt[17:10]);
   assign w_ymag = axis_mag(r_pkt[9],  r_pkt[8],  r_pkt[7:0]);

   assign w_tick     = ce && (r_div == '0);
   assign w_run_tick = (r_state == S_RUN) && w_tick;
   assign w_xhit     = w_run_tick && (r_xcnt != 9'd0);
   assign w_yhit     = w_run_tick && (r_ycnt != 9'd0);

   // NOTE: the storage array has no reset; stale entries are never read
   // because the pointers are reset, and leaving it unreset keeps it a RAM.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr[FIFO_AW-1:0]] <= w_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_old_stb <= 1'b0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_pkt     <= '0;
         r_ovf     <= 1'b0;
         r_div     <= '0;
      end else begin
         r_old_stb <= ps2_mouse[24];
         if (w_push)
            r_wptr <= r_wptr + PTR_ONE;
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
            r_pkt  <= r_mem[r_rptr[FIFO_AW-1:0]];
         end
         // A drop in the same cycle as clr_ovf wins
         if (w_drop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
         if (w_tick)
            r_div <= rate;
         else if (ce)
            r_div <= r_div - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // NOTE: next state defaults to the current state first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (!w_empty) w_next_state = S_LOAD;
         S_LOAD: w_next_state = ((w_xmag == 9'd0) && (w_ymag == 9'd0)) ? S_IDLE : S_RUN;
         S_RUN:  if (w_run_tick && (r_xcnt <= 9'd1) && (r_ycnt <= 9'd1))
                    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_xcnt   <= 9'd0;
         r_ycnt   <= 9'd0;
         r_xsgn   <= 1'b0;
         r_ysgn   <= 1'b0;
         r_button <= 1'b1;
         r_x_step <= 1'b0;
         r_y_step <= 1'b0;
         r_x_dir  <= 1'b0;
         r_y_dir  <= 1'b0;
      end else begin
         r_x_step <= w_xhit;
         r_y_step <= w_yhit;
         if (r_state == S_LOAD) begin
            r_xcnt   <= w_xmag;
            r_ycnt   <= w_ymag;
            r_xsgn   <= r_pkt[18];
            r_ysgn   <= r_pkt[8];
            r_button <= ~|r_pkt[22:20];
         end else begin
            if (w_xhit)
               r_xcnt <= r_xcnt - 9'd1;
            if (w_yhit)
               r_ycnt <= r_ycnt - 9'd1;
         end
         // Direction outputs only move with a pulse and hold in between
         if (w_xhit)
            r_x_dir <= r_xsgn;
         if (w_yhit)
            r_y_dir <= r_ysgn;
      end
   end

   assign x_step = r_x_step;
   assign x_dir  = r_x_dir;
   assign y_step = r_y_step;
   assign y_dir  = r_y_dir;
   assign button = r_button;
   assign ovf    = r_ovf;
   assign busy   = (r_state != S_IDLE) || !w_empty;

endmodule

// File: doc/mouse_step_sched.md
Name: mouse_step_sched

Overview:
Scheduler that sits between the HPS PS/2 mouse packet bus and the quadrature/joystick emulation logic. It buffers incoming mouse packets in a small FIFO. It then drains each packet as a paced sequence of single X/Y step pulses, with direction, at a programmable rate, so that downstream step consumers never lose motion. It also keeps the button state aligned with the movement it belongs to, and flags dropped packets.

Parameters:
FIFO_AW, 2, log2 of FIFO depth (default 4 entries)
DIV_W, 12, width of the step-rate divider and of the rate port

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ce  input  1  clock enable for step pacing
ps2_mouse  input  25  packet bus: [24] toggle strobe, [23:16] Y move, [15:8] X move, [7] YOVR, [6] XOVR, [5] YSGN, [4] XSGN, [2:0] buttons
rate  input  DIV_W  step period in ce cycles, minus one
clr_ovf  input  1  synchronous clear of ovf
x_step  output  1  one-clk pulse, one X step
x_dir  output  1  X direction, 1 = negative; valid with x_step
y_step  output  1  one-clk pulse, one Y step
y_dir  output  1  Y direction, 1 = negative; valid with y_step
button  output  1  active-low, 0 = any button pressed
busy  output  1  FSM not IDLE or FIFO not empty
ovf  output  1  sticky: a packet was dropped

Behaviour:
- Reset (async, reset_n=0): old_stb=0, FIFO empty, state=IDLE, divider=0, counters=0, x_step=y_step=0, x_dir=y_dir=0, button=1, ovf=0, busy=0.
- Strobe: strobe = ps2_mouse[24] XOR old_stb; old_stb <= ps2_mouse[24] every clk.
- Push:
  - On a clk with strobe=1, write entry {btn[2:0], XOVR, XSGN, X[7:0], YOVR, YSGN, Y[7:0]} (23 bits).
  - If FIFO is full and no pop happens that cycle: drop the entry and set ovf=1.
  - Simultaneous push and pop on a full FIFO: accept the push, no ovf.
  - clr_ovf clears ovf; a same-cycle drop wins, so ovf stays 1.
- Magnitude per axis: v = {SGN, MOVE} as 9-bit two's complement.
  - If OVR=1, mag = 255.
  - Otherwise mag = |v|, range 0..256 (-256 gives 256), held in a 9-bit counter.
  - dir = SGN.
- Divider: counts on ce only.
  - tick = ce AND div==0.
  - On tick, div <= rate; otherwise on ce, div <= div-1.
  - rate=0 gives a tick on every ce.
  - Divider free-runs in all states.
- FSM:
  - IDLE: if FIFO not empty, pop the head and go to LOAD.
  - LOAD (1 clk):
    - Load xcnt/xdir/ycnt/ydir from the popped entry; button <= ~|btn.
    - If xcnt=0 and ycnt=0, go to IDLE. Otherwise go to RUN.
  - RUN: on each tick, for each axis with cnt≠0:
    - Pulse <axis>_step for exactly one clk, with <axis>_dir = loaded sign.
    - Decrement that axis's cnt.
    - X and Y may pulse in the same clk.
    - When both counters reach 0 (evaluated after the decrement), go to IDLE.
- Latency:
  - Strobe at edge N: entry visible at edge N+1, pop at N+1 (IDLE), LOAD at N+2.
  - First step no earlier than the first tick after entering RUN.
  - Button changes at the LOAD edge.
- Ordering: packets are drained strictly FIFO. A packet is never merged with or truncated by a later one.
- x_dir/y_dir hold their last values between pulses.
- reset_n asserted mid-RUN aborts immediately. All state returns to reset values and no further pulses are issued.
- busy = (state≠IDLE) OR FIFO not empty.

Test Plan:
- Reset, then toggle bit24 once with X=+3, Y=0, rate=0, ce=1 -> exactly 3 x_step pulses on consecutive clks with x_dir=0, no y_step, busy returns to 0.
- X=0x00 with XSGN=1 (-256), rate=1 -> 256 x_step pulses with x_dir=1, spaced 2 ce apart.
- X=-2, Y=+5 in one packet -> 2 clks with x_step and y_step both high, then 3 with y_step only; y_dir=0, x_dir=1.
- XOVR=1, X=0x10 -> exactly 255 steps.
- Button packet btn=001 with X=+4, then btn=000 with X=0, Y=0 -> button falls at the first LOAD, rises at the second LOAD after all 4 steps have been issued.
- Six strobes back-to-back while rate=0xFFF -> first entry popped, 4 queued, 6th dropped: ovf=1. clr_ovf -> ovf=0. A mid-RUN reset_n pulse -> no further step pulses, busy=0, button=1.
